// File: rtl/pcpi_pkg.sv
// pcpi_pkg: shared types and constants for the PCPI issue controller
//   pcpi_state_t : issue FSM states
//   PCPI_OP/PCPI_FUNCT7 : opcode fields of the M-extension instructions served over PCPI
//   pcpi_req_t   : instruction plus operands held towards the coprocessors
//   pcpi_rsp_t   : result returned to the pipeline
package pcpi_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} pcpi_state_t;
  localparam logic [6:0] PCPI_OP = 7'b0110011;
  localparam logic [6:0] PCPI_FUNCT7 = 7'b0000001;
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } pcpi_req_t;
  typedef struct packed {
    logic wr;
    logic [31:0] rd;
    logic illegal;
  } pcpi_rsp_t;
endpackage

// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl: core-side PCPI initiator with claim timeout
//   clk, resetn        : clock, synchronous active-low reset
//   req_*              : pipeline request handshake (insn, rs1, rs2)
//   rsp_*              : pipeline response handshake (wr, rd, illegal)
//   pcpi_valid/insn/rs1/rs2 : held request towards the coprocessors
//   pcpi_wr/rd/wait/ready   : coprocessor claim and result
module pcpi_issue_ctrl
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic        rsp_illegal,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);
  pcpi_state_t state_q;
  logic [CW-1:0] cnt_q;
  pcpi_req_t req_q;
  pcpi_rsp_t rsp_q;
  logic pcpi_valid_q;
  logic rsp_valid_q;
  assign req_ready = state_q == IDLE;
  assign pcpi_valid = pcpi_valid_q;
  assign pcpi_insn = req_q.insn;
  assign pcpi_rs1 = req_q.rs1;
  assign pcpi_rs2 = req_q.rs2;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr = rsp_q.wr;
  assign rsp_rd = rsp_q.rd;
  assign rsp_illegal = rsp_q.illegal;
  // cnt_q counts the remaining unclaimed cycles; any pcpi_wait restarts the full window
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_q <= '0;
      rsp_q <= '0;
      pcpi_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          req_q <= '{insn: req_insn, rs1: req_rs1, rs2: req_rs2};
          pcpi_valid_q <= 1'b1;
          cnt_q <= CNT_LOAD;
          state_q <= ISSUE;
        end
        ISSUE: if (pcpi_ready) begin
          rsp_q <= '{wr: pcpi_wr, rd: pcpi_rd, illegal: 1'b0};
          rsp_valid_q <= 1'b1;
          pcpi_valid_q <= 1'b0;
          state_q <= RESP;
        end else if (pcpi_wait) begin
          cnt_q <= CNT_LOAD;
        end else if (cnt_q == '0) begin
          rsp_q <= '{wr: 1'b0, rd: 32'd0, illegal: 1'b1};
          rsp_valid_q <= 1'b1;
          pcpi_valid_q <= 1'b0;
          state_q <= RESP;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
        // rd is left as-is after the handshake; only the flags are cleared
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_q.wr <= 1'b0;
          rsp_q.illegal <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// tb_pcpi_issue_ctrl: randomized scoreboard bench for pcpi_issue_ctrl
module tb_pcpi_issue_ctrl;
  import pcpi_pkg::*;
  localparam int T = 16;
  typedef struct {
    logic wr;
    logic [31:0] rd;
    logic ill;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic req_valid = 1'b0;
  logic rsp_ready = 1'b1;
  logic [31:0] req_insn = '0, req_rs1 = '0, req_rs2 = '0;
  logic req_ready, rsp_valid, rsp_wr, rsp_illegal, pcpi_valid;
  logic [31:0] rsp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  int m_pre = 0, m_busy = 0, m_gap = 0;
  bit m_none = 0, m_comb = 0, m_wr = 0;
  bit r_ready = 0, r_wait = 0, rbusy = 0, spur_ready = 0, pv_prev = 0;
  bit bp_low = 0, rand_bp = 0, rv_prev = 0;
  logic [31:0] r_rd = '0, spur_rd = '0;
  logic [31:0] x_insn = '0, x_rs1 = '0, x_rs2 = '0;
  logic [33:0] snap = '0;
  int tests = 0, fails = 0, cyc = 0, acc_edge = 0, vcnt = 0, last_acc = 0, prev_acc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cop(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q;
    if (insn[14:12] == 3'b100) begin
      if (b == 32'd0) return 32'hFFFFFFFF;
      q = $signed(a) / $signed(b);
      return q;
    end
    return a * b;
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {PCPI_FUNCT7, 5'd2, 5'd1, f3, 5'd3, PCPI_OP};
  endfunction

  assign pcpi_ready = r_ready | spur_ready | (m_comb & pcpi_valid);
  assign pcpi_wait = r_wait;
  assign pcpi_wr = m_wr;
  assign pcpi_rd = spur_ready ? spur_rd : m_comb ? cop(pcpi_insn, pcpi_rs1, pcpi_rs2) : r_rd;

  pcpi_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // coprocessor that claims after pre cycles, stays busy, drops wait for gap cycles, then answers
  initial forever begin
    @(negedge clk);
    if (pcpi_valid && !pv_prev && !m_comb && !m_none) begin
      rbusy = 1;
      repeat (m_pre) @(negedge clk);
      if (m_busy > 0) begin
        r_wait = 1;
        repeat (m_busy) @(negedge clk);
        r_wait = 0;
      end
      repeat (m_gap) @(negedge clk);
      r_rd = cop(pcpi_insn, pcpi_rs1, pcpi_rs2);
      r_ready = 1;
      @(negedge clk);
      r_ready = 0;
      rbusy = 0;
    end
    pv_prev = pcpi_valid;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = bp_low ? 1'b0 : rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: latency and valid length at response rise, stability while held, contents at handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!resetn) begin
      vcnt = 0;
      rv_prev = 0;
    end else begin
      if (pcpi_valid) begin
        vcnt++;
        chk("pcpi_operands", {pcpi_insn, pcpi_rs1, pcpi_rs2}, {x_insn, x_rs1, x_rs2});
        chk("req_ready_in_issue", 96'(req_ready), 96'(0));
      end
      if (rsp_valid && !rv_prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=%0b expected no response (cycle %0d)", rsp_valid, cyc);
        end else begin
          chk("rsp_latency", 96'(cyc - acc_edge), 96'(sb[0].lat));
          chk("pcpi_valid_cycles", 96'(vcnt), 96'(sb[0].lat));
        end
        snap = {rsp_wr, rsp_illegal, rsp_rd};
      end
      if (rsp_valid && rv_prev) chk("rsp_stable", 96'({rsp_wr, rsp_illegal, rsp_rd}), 96'(snap));
      if (rsp_valid) chk("req_ready_in_resp", 96'(req_ready), 96'(0));
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_wr", 96'(rsp_wr), 96'(e.wr));
        chk("rsp_rd", 96'(rsp_rd), 96'(e.rd));
        chk("rsp_illegal", 96'(rsp_illegal), 96'(e.ill));
      end
      if (req_valid && req_ready) begin
        acc_edge = cyc + 1;
        vcnt = 0;
      end
      rv_prev = rsp_valid;
    end
  end

  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                       input int pre, input int busy, input int gap,
                       input bit none, input bit comb, input bit wr, input bit push,
                       input logic [31:0] erd);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk);
    #1;
    m_pre = pre;
    m_busy = busy;
    m_gap = gap;
    m_none = none;
    m_comb = comb;
    m_wr = wr;
    x_insn = insn;
    x_rs1 = rs1;
    x_rs2 = rs2;
    e.ill = none;
    e.wr = !none && wr;
    e.rd = none ? 32'd0 : erd;
    e.lat = none ? T : comb ? 1 : pre + busy + gap + 1;
    if (push) sb.push_back(e);
    req_valid = 1;
    req_insn = insn;
    req_rs1 = rs1;
    req_rs2 = rs2;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (++n > 500) begin
        bad("req_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    prev_acc = last_acc;
    last_acc = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !rbusy && req_ready) break;
      if (++n > 3000) begin
        bad("idle_wait");
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic [31:0] a, b, ins;
    int k, pre, busy, gap;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 96'(req_ready), 96'(1));
    chk("reset_pcpi_valid", 96'(pcpi_valid), 96'(0));
    chk("reset_rsp_valid", 96'(rsp_valid), 96'(0));
    chk("reset_rsp_flags", 96'({rsp_wr, rsp_illegal}), 96'(0));
    chk("reset_rsp_rd", 96'(rsp_rd), 96'(0));
    chk("reset_pcpi_ops", {pcpi_insn, pcpi_rs1, pcpi_rs2}, 96'(0));
    @(posedge clk);
    #1;
    resetn = 1;
    // divider: 100 / -7
    issue(mk(3'b100), 32'd100, 32'hFFFFFFF9, 2, 34, 0, 0, 0, 1, 1, 32'hFFFFFFF2);
    wait_idle();
    // unclaimed instruction
    issue(mk(3'b000), 32'd5, 32'd6, 0, 0, 0, 1, 0, 1, 1, 32'd0);
    wait_idle();
    // long busy
    issue(mk(3'b000), 32'h12345678, 32'd1, 0, 100, 0, 0, 0, 1, 1, 32'h12345678);
    wait_idle();
    // ready arrives in the last cycle of the window
    issue(mk(3'b000), 32'd3, 32'd9, T - 1, 0, 0, 0, 0, 0, 1, 32'd27);
    wait_idle();
    // wait-then-drop restarts the window
    issue(mk(3'b000), 32'd11, 32'd13, 5, 10, T - 1, 0, 0, 1, 1, 32'd143);
    wait_idle();
    // backpressure with a spurious ready in RESP
    bp_low = 1;
    issue(mk(3'b000), 32'd6, 32'd7, 1, 3, 0, 0, 0, 1, 1, 32'd42);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) bad("bp_rsp_wait");
    repeat (4) @(negedge clk);
    spur_rd = 32'hDEADBEEF;
    spur_ready = 1;
    @(negedge clk);
    spur_ready = 0;
    repeat (5) @(negedge clk);
    chk("bp_rd_after_spurious", 96'(rsp_rd), 96'(42));
    chk("bp_rsp_valid_held", 96'(rsp_valid), 96'(1));
    bp_low = 0;
    wait_idle();
    // reset while in ISSUE
    issue(mk(3'b000), 32'd2, 32'd2, 3, 10, 0, 0, 0, 1, 0, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    resetn = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    @(negedge clk);
    chk("rst_mid_pcpi_valid", 96'(pcpi_valid), 96'(0));
    chk("rst_mid_rsp_valid", 96'(rsp_valid), 96'(0));
    chk("rst_mid_req_ready", 96'(req_ready), 96'(1));
    wait_idle();
    repeat (5) @(negedge clk);
    // combinational responder, back-to-back
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      issue(mk(3'b000), a, b, 0, 0, 0, 0, 1, 1, 1, a * b);
      if (i > 0) chk("accept_spacing", 96'(last_acc - prev_acc), 96'(3));
    end
    wait_idle();
    // randomized traffic
    rand_bp = 1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 7);
      a = $urandom >> 1;
      b = $urandom | 32'd1;
      ins = mk($urandom_range(0, 1) ? 3'b100 : 3'b000);
      pre = $urandom_range(0, T - 1);
      busy = $urandom_range(0, 40);
      gap = busy == 0 ? $urandom_range(0, T - 1 - pre) : $urandom_range(0, T - 1);
      issue(ins, a, b, pre, busy, gap, k == 0, k == 1 || k == 2, 1'($urandom_range(0, 1)), 1, cop(ins, a, b));
      wait_idle();
    end
    rand_bp = 0;
    m_comb = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
